// File: rtl/clock_set_ctrl.sv
// Board clock time-keeper: hr/min/sec counters, 1 Hz prescaler and two-button set FSM.
// Define CLOCK_ALARM_EN to compile in the alarm-time registers, arming and compare output.
module clock_set_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic [2:0] state,
  output logic       alarm
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HR   = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_AHR  = 3'd3,
    ST_SET_AMIN = 3'd4
  } state_t;

  function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] vmax);
    if (v == vmax) wrap_inc6 = 6'd0;
    else           wrap_inc6 = v + 6'd1;
  endfunction

  function automatic logic [4:0] wrap_inc5(input logic [4:0] v, input logic [4:0] vmax);
    if (v == vmax) wrap_inc5 = 5'd0;
    else           wrap_inc5 = v + 5'd1;
  endfunction

  state_t        state_r, state_n_s;
  logic [PW-1:0] presc_r, presc_n_s;
  logic [5:0]    sec_r, sec_n_s, min_r, min_n_s;
  logic [4:0]    hr_r, hr_n_s;
  logic          mode_q_r, inc_q_r;
  logic          mode_press_s, inc_press_s, mode_eff_s;
  logic          running_s, tick_s;

`ifdef CLOCK_ALARM_EN
  logic [4:0] ahr_r, ahr_n_s;
  logic [5:0] amin_r, amin_n_s;
  logic [5:0] acnt_r, acnt_n_s;
  logic       armed_r, armed_n_s;
  logic       alarm_r, alarm_n_s;
`endif

  // Button edge detection; a simultaneous mode press discards the inc press
  always_comb begin
    mode_press_s = mode_btn & ~mode_q_r;
    inc_press_s  = inc_btn & ~inc_q_r & ~mode_press_s;
`ifdef CLOCK_ALARM_EN
    // a mode press while the alarm is sounding only acknowledges it
    mode_eff_s   = mode_press_s & ~alarm_r;
`else
    mode_eff_s   = mode_press_s;
`endif
    running_s    = (state_r != ST_SET_HR) && (state_r != ST_SET_MIN);
    tick_s       = running_s && (presc_r == PRESC_LAST);
  end

  // Next-state logic for the mode sequence
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (mode_eff_s) state_n_s = ST_SET_HR;
        else            state_n_s = ST_RUN;
      end
      ST_SET_HR: begin
        if (mode_eff_s) state_n_s = ST_SET_MIN;
        else            state_n_s = ST_SET_HR;
      end
      ST_SET_MIN: begin
`ifdef CLOCK_ALARM_EN
        if (mode_eff_s) state_n_s = ST_SET_AHR;
`else
        if (mode_eff_s) state_n_s = ST_RUN;
`endif
        else            state_n_s = ST_SET_MIN;
      end
`ifdef CLOCK_ALARM_EN
      ST_SET_AHR: begin
        if (mode_eff_s) state_n_s = ST_SET_AMIN;
        else            state_n_s = ST_SET_AHR;
      end
      ST_SET_AMIN: begin
        if (mode_eff_s) state_n_s = ST_RUN;
        else            state_n_s = ST_SET_AMIN;
      end
`endif
      default: state_n_s = ST_RUN;
    endcase
  end

  // Time and prescaler update: frozen while setting, ticking otherwise
  always_comb begin
    sec_n_s   = sec_r;
    min_n_s   = min_r;
    hr_n_s    = hr_r;
    presc_n_s = PRESC_ZERO;
    case (state_r)
      ST_SET_HR: begin
        if (inc_press_s) hr_n_s = wrap_inc5(hr_r, 5'd23);
        else             hr_n_s = hr_r;
      end
      ST_SET_MIN: begin
        if (inc_press_s) min_n_s = wrap_inc6(min_r, 6'd59);
        else             min_n_s = min_r;
        // leaving time-set restarts the second from zero
        if (mode_eff_s)  sec_n_s = 6'd0;
        else             sec_n_s = sec_r;
      end
      default: begin
        if (tick_s) begin
          presc_n_s = PRESC_ZERO;
          sec_n_s   = wrap_inc6(sec_r, 6'd59);
          if (sec_r == 6'd59) begin
            min_n_s = wrap_inc6(min_r, 6'd59);
            if (min_r == 6'd59) hr_n_s = wrap_inc5(hr_r, 5'd23);
            else                hr_n_s = hr_r;
          end else begin
            min_n_s = min_r;
          end
        end else begin
          presc_n_s = presc_r + PRESC_ONE;
        end
      end
    endcase
  end

  // State, time, prescaler and button history registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_RUN;
      presc_r  <= PRESC_ZERO;
      sec_r    <= 6'd0;
      min_r    <= 6'd0;
      hr_r     <= 5'd0;
      mode_q_r <= 1'b0;
      inc_q_r  <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      presc_r  <= presc_n_s;
      sec_r    <= sec_n_s;
      min_r    <= min_n_s;
      hr_r     <= hr_n_s;
      mode_q_r <= mode_btn;
      inc_q_r  <= inc_btn;
    end
  end

`ifdef CLOCK_ALARM_EN
  // Alarm time editing, arming, compare and auto-clear after 60 ticks
  always_comb begin
    ahr_n_s   = ahr_r;
    amin_n_s  = amin_r;
    armed_n_s = armed_r;
    alarm_n_s = alarm_r;
    acnt_n_s  = acnt_r;
    if ((state_r == ST_SET_AHR) && inc_press_s) ahr_n_s = wrap_inc5(ahr_r, 5'd23);
    else                                        ahr_n_s = ahr_r;
    if ((state_r == ST_SET_AMIN) && inc_press_s) amin_n_s = wrap_inc6(amin_r, 6'd59);
    else                                         amin_n_s = amin_r;
    if ((state_r == ST_SET_AMIN) && mode_eff_s) armed_n_s = 1'b1;
    else                                        armed_n_s = armed_r;
    if (alarm_r) begin
      if (mode_press_s) begin
        alarm_n_s = 1'b0;
        acnt_n_s  = 6'd0;
      end else if (tick_s) begin
        if (acnt_r == 6'd59) begin
          alarm_n_s = 1'b0;
          acnt_n_s  = 6'd0;
        end else begin
          acnt_n_s  = acnt_r + 6'd1;
        end
      end else begin
        acnt_n_s = acnt_r;
      end
    end else if (tick_s && (sec_r == 6'd59) && armed_r &&
                 (hr_n_s == ahr_r) && (min_n_s == amin_r)) begin
      alarm_n_s = 1'b1;
      acnt_n_s  = 6'd0;
    end else begin
      alarm_n_s = 1'b0;
    end
  end

  // Alarm registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ahr_r   <= 5'd0;
      amin_r  <= 6'd0;
      acnt_r  <= 6'd0;
      armed_r <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      ahr_r   <= ahr_n_s;
      amin_r  <= amin_n_s;
      acnt_r  <= acnt_n_s;
      armed_r <= armed_n_s;
      alarm_r <= alarm_n_s;
    end
  end

  assign alarm = alarm_r;
`else
  assign alarm = 1'b0;
`endif

  assign sec   = sec_r;
  assign min   = min_r;
  assign hr    = hr_r;
  assign state = state_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl with TICK_DIV=4.
// Alarm scenarios are exercised only when CLOCK_ALARM_EN is defined.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_btn;
  logic       inc_btn;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic [2:0] state;
  logic       alarm;

  int n_tests = 0;
  int n_fail  = 0;

  clock_set_ctrl #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .sec      (sec),
    .min      (min),
    .hr       (hr),
    .state    (state),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hr"}, int'(hr), h);
    check({tag, ".min"}, int'(min), m);
    check({tag, ".sec"}, int'(sec), s);
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    step(1);
    mode_btn = 1'b0;
    step(1);
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      inc_btn = 1'b1;
      step(1);
      inc_btn = 1'b0;
      step(1);
    end
  endtask

  initial begin
    int exp_seq[$];
    int waited;
    rst      = 1'b0;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    step(2);
    check_time("reset", 0, 0, 0);
    check("reset.state", int'(state), 0);
    check("reset.alarm", int'(alarm), 0);
    rst = 1'b1;

    // free run: one tick every 4 cycles, 240 cycles = one minute
    for (int k = 1; k <= 240; k++) begin
      step(1);
      check("run.sec", int'(sec), (k / 4) % 60);
      check("run.state", int'(state), 0);
    end
    check_time("run_1min", 0, 1, 0);
    step(8);
    check_time("run_2s", 0, 1, 2);

    // enter SET_HR; time frozen
    mode_btn = 1'b1;
    step(1);
    check("enter_hr.state", int'(state), 1);
    check_time("enter_hr", 0, 1, 2);
    mode_btn = 1'b0;
    step(1);

    // held inc button counts once
    inc_btn = 1'b1;
    step(10);
    inc_btn = 1'b0;
    step(1);
    check("hold_once.hr", int'(hr), 1);
    press_inc(24);
    check("wrap24.hr", int'(hr), 1);
    press_inc(22);
    check("set23.hr", int'(hr), 23);

    // simultaneous mode+inc: mode wins
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    step(1);
    check("mode_inc.state", int'(state), 2);
    check_time("mode_inc", 23, 1, 2);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    step(1);

    press_inc(58);
    check_time("set_min59", 23, 59, 2);
    step(5);
    check("frozen.sec", int'(sec), 2);

    // exit SET_MIN: sec cleared, first tick 4 cycles later
    mode_btn = 1'b1;
    step(1);
    check("exit.state", int'(state), 0);
    check_time("exit", 23, 59, 0);
    mode_btn = 1'b0;
    step(3);
    check("pre_tick.sec", int'(sec), 0);
    step(1);
    check("first_tick.sec", int'(sec), 1);
    step(235);
    check_time("pre_wrap", 23, 59, 59);
    step(1);
    check_time("day_wrap", 0, 0, 0);

    // reset in the middle of SET_MIN
    press_mode();
    press_mode();
    press_inc(37);
    check("midset.state", int'(state), 2);
    check("midset.min", int'(min), 37);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check_time("midset_rst", 0, 0, 0);
    check("midset_rst.state", int'(state), 0);
    check("midset_rst.alarm", int'(alarm), 0);

    // full mode cycle
`ifdef CLOCK_ALARM_EN
    exp_seq = '{1, 2, 3, 4, 0};
`else
    exp_seq = '{1, 2, 0};
`endif
    foreach (exp_seq[i]) begin
      mode_btn = 1'b1;
      step(1);
      check("cycle.state", int'(state), exp_seq[i]);
      check("cycle.alarm", int'(alarm), 0);
      mode_btn = 1'b0;
      step(1);
    end

`ifdef CLOCK_ALARM_EN
    // arm alarm at 00:01 starting from a clean reset
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    press_mode();
    press_mode();
    press_mode();
    press_mode();
    press_inc(1);
    press_mode();
    check("arm.state", int'(state), 0);
    check_time("arm", 0, 0, 1);
    step(1);
    check("arm_next.sec", int'(sec), 2);
    step(228);
    check_time("pre_alarm", 0, 0, 59);
    check("pre_alarm.alarm", int'(alarm), 0);
    step(4);
    check_time("alarm_hit", 0, 1, 0);
    check("alarm_hit.alarm", int'(alarm), 1);
    mode_btn = 1'b1;
    step(1);
    check("ack.alarm", int'(alarm), 0);
    check("ack.state", int'(state), 0);
    mode_btn = 1'b0;
    step(1);

    // re-arm at 00:03 and let it time out
    press_mode();
    press_mode();
    press_mode();
    press_mode();
    press_inc(2);
    press_mode();
    waited = 0;
    while (alarm !== 1'b1 && waited < 2000) begin
      step(1);
      waited++;
    end
    check("alarm2.raise", int'(alarm), 1);
    check_time("alarm2", 0, 3, 0);
    step(239);
    check("alarm2.hold", int'(alarm), 1);
    step(1);
    check("alarm2.timeout", int'(alarm), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
